clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Owns the `div_factor` register that feeds the shared programmable clock divider.
- Lets NREQ requesters reprogram the divider through a req/ack handshake, with round-robin arbitration between them.
- Applies each accepted factor only at a safe point: the divider's low phase, together with a one-cycle divider restart.
- The restart is required because the divider compares `counter == factor/2-1`. Shrinking the factor mid-count would otherwise run the counter through a 2^32 wrap.

Parameters:
- NREQ, 4, number of requesters.
- WIDTH, 32, factor width.
- DEFAULT_FACTOR, 100000000, factor loaded at reset.
- MIN_FACTOR, 4, smallest accepted factor (must be even and ≥4).
- TIMEOUT_CYCLES, 1024, WAIT_EDGE bound; used only with the optional feature.

Ports:
- clk_in  in  1  system clock
- rst_  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- req_factor  in  NREQ*WIDTH  requested factor; slice i belongs to requester i
- ack  out  NREQ  one-cycle pulse: request i committed
- err  out  NREQ  one-cycle pulse: request i rejected
- clk_div_fb  in  1  divider output fed back (asynchronous to clk_in logic)
- div_factor  out  WIDTH  factor driven to the divider
- div_rst_  out  1  active-low divider restart
- busy  out  1  high while a request is in flight
- owner  out  $clog2(NREQ)  index of the last committed requester
- timeout  out  1  one-cycle pulse: commit forced by timeout

Behaviour:
- Reset values:
  - `div_factor` = DEFAULT_FACTOR & ~1.
  - `ack`, `err`, `busy`, `owner`, `timeout` = 0.
  - `div_rst_` = 1.
  - State IDLE, round-robin pointer 0, synchronizer flops 0.
- `clk_div_fb` passes through a 2-flop synchronizer. A falling edge is detected when the synced value goes 1 -> 0.
- States:
  - IDLE: if any `req` is high, grant the round-robin winner (search starts at the pointer), latch its index and factor, go to CHECK. Pointer becomes winner+1, mod NREQ.
  - CHECK:
    - factor < MIN_FACTOR: pulse `err[i]`, go to IDLE.
    - Otherwise clear bit 0 (round down to even).
    - If the result equals `div_factor`: pulse `ack[i]`, go to IDLE with no restart.
    - Else go to WAIT_EDGE.
  - WAIT_EDGE: wait for a synced falling edge, then go to COMMIT.
  - COMMIT (one cycle):
    - `div_factor` <= pending factor.
    - `div_rst_` = 0.
    - `ack[i]` = 1, `owner` <= i.
    - Go to IDLE.
- `busy` = 1 in CHECK, WAIT_EDGE and COMMIT.
- All outputs are registered.
- Handshake rules:
  - A requester holds `req` and a stable `req_factor` until it sees `ack` or `err`.
  - It drops `req` on the following edge.
  - `req` is sampled only in IDLE, so requests raised while busy wait.
  - Dropping `req` before ack is illegal; the latched factor is still committed.
- Simultaneous requests: exactly one is granted per IDLE visit; losers stay pending.
- Latency:
  - IDLE sample -> CHECK: 1 cycle.
  - Equal-factor or reject path: ack/err one cycle after CHECK entry.
  - Change path: COMMIT on the cycle after the edge is detected, i.e. 3 clk_in cycles after the raw `clk_div_fb` fall, plus the wait for that fall.
- Reset mid-operation: pending factor discarded, no ack/err emitted, everything returns to reset values.

Optional Feature:
- CLK_DIV_CTRL_TIMEOUT_EN defined:
  - A WAIT_EDGE cycle counter runs from entry into WAIT_EDGE.
  - At TIMEOUT_CYCLES without an edge, go to COMMIT anyway and pulse `timeout` with the `ack`.
  - This recovers from a stalled divider, e.g. a previous huge factor.
- Undefined: WAIT_EDGE waits indefinitely, the counter is absent, and `timeout` is tied 0.

Decomposition:
- Package `clk_div_ctrl_pkg`:
  - State enum (IDLE, CHECK, WAIT_EDGE, COMMIT).
  - Default WIDTH, MIN_FACTOR and DEFAULT_FACTOR constants.
- Sub-module `rr_arbiter`: NREQ-wide round-robin grant with pointer update, combinational grant plus registered pointer. Reusable for other shared resources.

Test Plan:
- Reset with no `req` -> `div_factor`=100000000, `div_rst_`=1, `busy`=0, all `ack`/`err` low.
- `req[1]` with factor 10 while the divider runs at DEFAULT -> no change before the `clk_div_fb` fall; on COMMIT `div_factor`=10, `div_rst_` low exactly 1 cycle, `ack[1]` 1 cycle, `owner`=1.
- `req[0]`=7 and `req[2]`=3 in the same cycle:
  - Requester 0 granted first: `ack[0]`, `div_factor`=6.
  - Then requester 2: `err[2]` (3 < 4), `div_factor` stays 6.
  - Pointer check: next simultaneous `req[0]`+`req[3]` grants requester 3 first.
- `req[3]` with factor equal to the current `div_factor` -> `ack[3]` two cycles after the IDLE sample, `div_rst_` stays 1.
- `rst_` low during WAIT_EDGE -> no `ack`, `div_factor` back to DEFAULT, state IDLE.
- With CLK_DIV_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, `clk_div_fb` held at 0 -> COMMIT after 16 WAIT_EDGE cycles, `timeout` and `ack` pulse together. Without the macro -> stays busy indefinitely.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | clk_div_ctrl_pkg: shared state encoding and default constants.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package clk_div_ctrl_pkg;

    localparam int CDC_WIDTH          = 32;
    localparam int CDC_MIN_FACTOR     = 4;
    localparam int CDC_DEFAULT_FACTOR = 100000000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CHECK     = 2'd1,
        ST_WAIT_EDGE = 2'd2,
        ST_COMMIT    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter: round-robin grant, search starts at the registered pointer.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk_in,
    input  logic            rst_,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    output logic            valid_o,
    output logic [IDXW-1:0] grant_idx_o
);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        valid_o     = 1'b0;
        grant_idx_o = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (req_i[idx]) begin
                valid_o     = 1'b1;
                grant_idx_o = IDXW'(idx);
            end
        end
        ptr_d = (grant_idx_o == IDXW'(NREQ - 1)) ? '0 : grant_idx_o + IDXW'(1);
    end

    always_ff @(posedge clk_in or negedge rst_) begin
        if (!rst_) begin
            ptr_q <= '0;
        end else if (advance_i && valid_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// +----------------------------------------------------------------------------+
// | clk_div_ctrl: arbitrated, glitch-safe reprogramming of the divider factor. |
// | Optional macro CLK_DIV_CTRL_TIMEOUT_EN bounds the wait for a low phase.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int WIDTH          = CDC_WIDTH,
    parameter int DEFAULT_FACTOR = CDC_DEFAULT_FACTOR,
    parameter int MIN_FACTOR     = CDC_MIN_FACTOR,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_in,
    input  logic                     rst_,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_factor,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          err,
    input  logic                     clk_div_fb,
    output logic [WIDTH-1:0]         div_factor,
    output logic                     div_rst_,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     timeout
);

    localparam int IDXW = $clog2(NREQ);
    localparam logic [WIDTH-1:0] RST_FACTOR = WIDTH'(DEFAULT_FACTOR) & ~WIDTH'(1);

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  pend_q, pend_d;
    logic [WIDTH-1:0]  div_factor_q, div_factor_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              div_rst_q, div_rst_d;
    logic              busy_q, busy_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic              timeout_q, timeout_d;
    logic              fb_s1_q, fb_s2_q, fb_s3_q;

    logic              w_valid;
    logic [IDXW-1:0]   w_gidx;
    logic [WIDTH-1:0]  w_sel_factor;
    logic [WIDTH-1:0]  w_even;
    logic              w_fall;
    logic              w_tmo_hit;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_in      (clk_in),
        .rst_        (rst_),
        .req_i       (req),
        .advance_i   (state_q == ST_IDLE),
        .valid_o     (w_valid),
        .grant_idx_o (w_gidx)
    );

    assign w_sel_factor = req_factor[w_gidx*WIDTH +: WIDTH];
    assign w_even       = pend_q & ~WIDTH'(1);
    assign w_fall       = fb_s3_q & ~fb_s2_q;

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    // Counts cycles spent in WAIT_EDGE; cleared whenever we are elsewhere.
    always_ff @(posedge clk_in or negedge rst_) begin
        if (!rst_) begin
            tmo_q <= '0;
        end else if (state_q != ST_WAIT_EDGE) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign w_tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        div_factor_d = div_factor_q;
        ack_d        = '0;
        err_d        = '0;
        div_rst_d    = 1'b1;
        owner_d      = owner_q;
        timeout_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (w_valid) begin
                    idx_d   = w_gidx;
                    pend_d  = w_sel_factor;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (pend_q < WIDTH'(MIN_FACTOR)) begin
                    err_d[idx_q] = 1'b1;
                    state_d      = ST_IDLE;
                end else if (w_even == div_factor_q) begin
                    ack_d[idx_q] = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    pend_d  = w_even;
                    state_d = ST_WAIT_EDGE;
                end
            end
            ST_WAIT_EDGE: begin
                // New factor and restart land together, during the low phase.
                if (w_fall || w_tmo_hit) begin
                    timeout_d    = ~w_fall;
                    div_factor_d = pend_q;
                    div_rst_d    = 1'b0;
                    ack_d[idx_q] = 1'b1;
                    owner_d      = idx_q;
                    state_d      = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_) begin
        if (!rst_) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            pend_q       <= '0;
            div_factor_q <= RST_FACTOR;
            ack_q        <= '0;
            err_q        <= '0;
            div_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            owner_q      <= '0;
            timeout_q    <= 1'b0;
            fb_s1_q      <= 1'b0;
            fb_s2_q      <= 1'b0;
            fb_s3_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            div_factor_q <= div_factor_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            div_rst_q    <= div_rst_d;
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            timeout_q    <= timeout_d;
            fb_s1_q      <= clk_div_fb;
            fb_s2_q      <= fb_s1_q;
            fb_s3_q      <= fb_s2_q;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign div_factor = div_factor_q;
    assign div_rst_   = div_rst_q;
    assign busy       = busy_q;
    assign owner      = owner_q;
    assign timeout    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_clk_div_ctrl: directed self-checking bench for clk_div_ctrl.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_clk_div_ctrl;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clk_in = 1'b0;
    logic                  rst_   = 1'b0;
    logic [NREQ-1:0]       req    = '0;
    logic [NREQ*WIDTH-1:0] req_factor = '0;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       err;
    logic                  clk_div_fb = 1'b1;
    logic [WIDTH-1:0]      div_factor;
    logic                  div_rst_;
    logic                  busy;
    logic [1:0]            owner;
    logic                  timeout;

    int n_checks = 0;
    int n_errors = 0;
    int fb_mode  = 0;   // 0: hold high, 1: hold low, 2: free-running

    clk_div_ctrl #(
        .NREQ           (NREQ),
        .WIDTH          (WIDTH),
        .DEFAULT_FACTOR (100000000),
        .MIN_FACTOR     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_in     (clk_in),
        .rst_       (rst_),
        .req        (req),
        .req_factor (req_factor),
        .ack        (ack),
        .err        (err),
        .clk_div_fb (clk_div_fb),
        .div_factor (div_factor),
        .div_rst_   (div_rst_),
        .busy       (busy),
        .owner      (owner),
        .timeout    (timeout)
    );

    always #5 clk_in = ~clk_in;

    // Divider feedback, deliberately asynchronous to clk_in.
    initial begin
        forever begin
            #37;
            case (fb_mode)
                0:       clk_div_fb = 1'b1;
                1:       clk_div_fb = 1'b0;
                default: clk_div_fb = ~clk_div_fb;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] f);
        req_factor[i*WIDTH +: WIDTH] = f;
        req[i] = 1'b1;
    endtask

    task automatic wait_pulse(input string tag, input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk_in);
            if ((ack | err) != '0) break;
        end
        check(tag, 64'(|(ack | err)), 64'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        rst_ = 1'b1;
        repeat (3) @(negedge clk_in);

        // Reset state
        check("rst_factor",  div_factor, 64'd100000000);
        check("rst_divrst",  div_rst_,   64'd1);
        check("rst_busy",    busy,       64'd0);
        check("rst_ack",     ack,        64'd0);
        check("rst_err",     err,        64'd0);
        check("rst_owner",   owner,      64'd0);
        check("rst_timeout", timeout,    64'd0);

        // Change path: nothing commits until the feedback falls
        set_req(1, 32'd10);
        repeat (20) @(negedge clk_in);
        check("hold_busy",   busy,       64'd1);
        check("hold_factor", div_factor, 64'd100000000);
        check("hold_ack",    ack,        64'd0);
        fb_mode = 1;
        wait_pulse("commit1_seen", 20);
        check("commit1_ack",    ack,        64'b0010);
        check("commit1_divrst", div_rst_,   64'd0);
        check("commit1_factor", div_factor, 64'd10);
        check("commit1_owner",  owner,      64'd1);
        req = '0;
        @(negedge clk_in);
        check("commit1_divrst_after", div_rst_, 64'd1);
        check("commit1_ack_after",    ack,      64'd0);
        check("commit1_busy_after",   busy,     64'd0);

        // Reset while waiting for the edge
        fb_mode = 0;
        repeat (10) @(negedge clk_in);
        set_req(1, 32'd20);
        repeat (6) @(negedge clk_in);
        check("midrst_busy_before", busy, 64'd1);
        rst_ = 1'b0;
        req  = '0;
        repeat (2) @(negedge clk_in);
        check("midrst_ack",    ack,        64'd0);
        check("midrst_factor", div_factor, 64'd100000000);
        check("midrst_busy",   busy,       64'd0);
        check("midrst_divrst", div_rst_,   64'd1);
        rst_ = 1'b1;
        repeat (3) @(negedge clk_in);
        check("midrst_idle", busy, 64'd0);

        // Simultaneous requests, pointer at 0 after reset
        fb_mode = 2;
        set_req(0, 32'd7);
        set_req(2, 32'd3);
        wait_pulse("sim_first_seen", 200);
        check("sim_first_ack",    ack,        64'b0001);
        check("sim_first_err",    err,        64'd0);
        check("sim_first_factor", div_factor, 64'd6);
        check("sim_first_owner",  owner,      64'd0);
        req[0] = 1'b0;
        wait_pulse("sim_second_seen", 10);
        check("sim_second_err", err, 64'b0100);
        check("sim_second_ack", ack, 64'd0);
        req[2] = 1'b0;
        @(negedge clk_in);
        check("sim_second_factor", div_factor, 64'd6);

        // Pointer now at 3; equal-factor fast path
        set_req(0, 32'd6);
        set_req(3, 32'd7);
        @(negedge clk_in);
        check("eq_busy", busy, 64'd1);
        check("eq_ack_early", ack, 64'd0);
        @(negedge clk_in);
        check("eq_ack3",   ack,      64'b1000);
        check("eq_divrst", div_rst_, 64'd1);
        req[3] = 1'b0;
        wait_pulse("eq0_seen", 10);
        check("eq0_ack",    ack,        64'b0001);
        check("eq0_divrst", div_rst_,   64'd1);
        check("eq0_factor", div_factor, 64'd6);
        check("eq0_owner",  owner,      64'd0);
        req[0] = 1'b0;

        // Stalled divider
        fb_mode = 1;
        repeat (10) @(negedge clk_in);
        set_req(1, 32'd8);
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        wait_pulse("tmo_seen", 40);
        check("tmo_ack",     ack,        64'b0010);
        check("tmo_timeout", timeout,    64'd1);
        check("tmo_factor",  div_factor, 64'd8);
        check("tmo_divrst",  div_rst_,   64'd0);
`else
        repeat (100) @(negedge clk_in);
        check("stall_busy",    busy,       64'd1);
        check("stall_ack",     ack,        64'd0);
        check("stall_timeout", timeout,    64'd0);
        check("stall_factor",  div_factor, 64'd6);
`endif
        req = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
